// File: rtl/adc_xfer_pkg.sv
// Shared types and constants for the ADC capture / transfer path.
package adc_xfer_pkg;

    localparam int unsigned ADC_SAMPLE_BITS = 16;
    localparam int unsigned ADC_WORD_W      = 256;
    localparam int unsigned ADC_HALF_W      = 128;

    // Which half of the held word (if any) is being presented downstream.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOWER = 2'd1,
        UPPER = 2'd2
    } unpack_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear first, otherwise increment unless already all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/adc_unpack_x2.sv
// 2:1 AXI4-Stream width converter: each wide ADC word leaves as two half beats,
// lower half first, with a saturating count of upstream stall cycles.
module adc_unpack_x2
    import adc_xfer_pkg::*;
#(
    parameter int unsigned DWIDTH_IN  = ADC_WORD_W,
    parameter int unsigned DWIDTH_OUT = ADC_HALF_W,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DWIDTH_IN-1:0]  s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DWIDTH_OUT-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [CNT_WIDTH-1:0]  stall_count,
    input  logic                  stall_clear
);

    // Build-time guard: the split only makes sense for an exact 2:1 ratio.
    generate
        if (DWIDTH_IN != 2 * DWIDTH_OUT) begin : g_bad_width
            $error("adc_unpack_x2: DWIDTH_IN must equal 2 * DWIDTH_OUT");
        end
    endgenerate

    unpack_state_t        state_q;
    unpack_state_t        state_d;
    logic [DWIDTH_IN-1:0] hold_data_q;
    logic [DWIDTH_IN-1:0] hold_data_d;
    logic                 hold_last_q;
    logic                 hold_last_d;
    logic                 s_ready_c;
    logic                 load_c;
    logic                 stall_c;

    // Next-state and upstream ready; a new word is loaded from EMPTY, or from
    // UPPER in the same cycle its upper half retires (no bubble).
    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        s_ready_c   = 1'b0;
        load_c      = 1'b0;

        case (state_q)
            EMPTY: begin
                s_ready_c = 1'b1;
                if (s_axis_tvalid) begin
                    load_c  = 1'b1;
                    state_d = LOWER;
                end
            end
            LOWER: begin
                if (m_axis_tready) begin
                    state_d = UPPER;
                end
            end
            UPPER: begin
                s_ready_c = m_axis_tready;
                if (m_axis_tready) begin
                    if (s_axis_tvalid) begin
                        load_c  = 1'b1;
                        state_d = LOWER;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (load_c) begin
            hold_data_d = s_axis_tdata;
            hold_last_d = s_axis_tlast;
        end
    end

    // State and hold registers; reset drops any partially sent word.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= EMPTY;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
        end
    end

    // Downstream side is decoded purely from registers, so it cannot glitch
    // on m_axis_tready and stays stable while a beat is stalled.
    always_comb begin
        m_axis_tvalid = (state_q != EMPTY);
        m_axis_tlast  = (state_q == UPPER) & hold_last_q;
        if (state_q == UPPER) begin
            m_axis_tdata = hold_data_q[DWIDTH_OUT +: DWIDTH_OUT];
        end else begin
            m_axis_tdata = hold_data_q[0 +: DWIDTH_OUT];
        end
    end

    // Upstream ready is forced low while reset is asserted.
    assign s_axis_tready = s_ready_c & ~areset;
    assign stall_c       = s_axis_tvalid & ~s_axis_tready;

    // Stall statistics for detecting lost ADC data.
    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk_i   (aclk),
        .rst_i   (areset),
        .inc     (stall_c),
        .clr     (stall_clear),
        .count_o (stall_count)
    );

endmodule

// File: tb/tb_adc_unpack_x2.sv
// Bench for adc_unpack_x2: directed vector table, random traffic against a
// beat-queue model, counter saturation and asynchronous reset mid-word.
module tb_adc_unpack_x2;

    localparam int unsigned DW_IN  = 256;
    localparam int unsigned DW_OUT = 128;
    localparam int unsigned CW     = 16;
    localparam int unsigned CW_S   = 4;
    localparam int unsigned NV     = 14;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic [DW_IN-1:0]  s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tlast;
    logic              m_axis_tready;
    logic              stall_clear;

    logic              s_axis_tready;
    logic [DW_OUT-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic [CW-1:0]     stall_count;

    logic              s_axis_tready_s;
    logic [DW_OUT-1:0] m_axis_tdata_s;
    logic              m_axis_tvalid_s;
    logic              m_axis_tlast_s;
    logic [CW_S-1:0]   stall_count_s;

    adc_unpack_x2 #(.DWIDTH_IN(DW_IN), .DWIDTH_OUT(DW_OUT), .CNT_WIDTH(CW)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .stall_count(stall_count), .stall_clear(stall_clear)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    adc_unpack_x2 #(.DWIDTH_IN(DW_IN), .DWIDTH_OUT(DW_OUT), .CNT_WIDTH(CW_S)) dut_s (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready_s), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata_s), .m_axis_tvalid(m_axis_tvalid_s),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast_s),
        .stall_count(stall_count_s), .stall_clear(stall_clear)
    );

    always #5 aclk = ~aclk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: every accepted word becomes two queued beats.
    typedef struct packed {
        logic              last;
        logic [DW_OUT-1:0] data;
    } beat_t;

    beat_t             q[$];
    int unsigned       m_cnt   = 0;
    int unsigned       m_cnt_s = 0;
    logic              exp_ready;
    logic              prev_stall = 1'b0;
    logic [DW_OUT-1:0] prev_data;
    logic              prev_last;

    // Cycle monitor at the falling edge: compare, then advance the model.
    always @(negedge aclk) begin
        if (areset) begin
            chk("rst_m_tvalid", m_axis_tvalid, 0);
            chk("rst_s_tready", s_axis_tready, 0);
            chk("rst_m_tdata", m_axis_tdata, 0);
            chk("rst_m_tlast", m_axis_tlast, 0);
            chk("rst_stall_count", stall_count, 0);
            q.delete();
            m_cnt      = 0;
            m_cnt_s    = 0;
            prev_stall = 1'b0;
        end else begin
            exp_ready = (q.size() == 0) || (q.size() == 1 && m_axis_tready);
            chk("mon_s_tready", s_axis_tready, exp_ready);
            chk("mon_m_tvalid", m_axis_tvalid, q.size() != 0);
            if (q.size() != 0) begin
                chk("mon_m_tdata", m_axis_tdata, q[0].data);
                chk("mon_m_tlast", m_axis_tlast, q[0].last);
            end
            if (prev_stall) chk("mon_stable", {m_axis_tlast, m_axis_tdata}, {prev_last, prev_data});
            chk("mon_stall_count", stall_count, m_cnt);
            chk("mon_stall_count_s", stall_count_s, m_cnt_s);
            chk("mon_narrow_inst", {s_axis_tready_s, m_axis_tvalid_s, m_axis_tlast_s, m_axis_tdata_s},
                {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata});
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (q.size() != 0 && m_axis_tready) void'(q.pop_front());
            if (s_axis_tvalid && exp_ready) begin
                q.push_back({1'b0, s_axis_tdata[DW_OUT-1:0]});
                q.push_back({s_axis_tlast, s_axis_tdata[DW_IN-1:DW_OUT]});
            end
            if (stall_clear) begin
                m_cnt   = 0;
                m_cnt_s = 0;
            end else if (s_axis_tvalid && !exp_ready) begin
                if (m_cnt < (2 ** CW) - 1) m_cnt++;
                if (m_cnt_s < (2 ** CW_S) - 1) m_cnt_s++;
            end
        end
    end

    typedef struct {
        logic              sv;
        logic [DW_IN-1:0]  sd;
        logic              sl;
        logic              ev;
        logic [DW_OUT-1:0] ed;
        logic              el;
        logic              er;
        logic [CW-1:0]     ec;
    } vec_t;

    vec_t             tbl[NV];
    logic [DW_IN-1:0] w0;
    logic [DW_IN-1:0] wk[6];
    logic [DW_IN-1:0] wsat;
    logic [DW_IN-1:0] wnew;
    bit               hs;
    int unsigned      words;
    int unsigned      cyc;

    function automatic logic [DW_IN-1:0] mkw(input logic [15:0] n);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = 16'h1000 + n;
        hi = 16'h2000 + n;
        return {{8{hi}}, {8{lo}}};
    endfunction

    task automatic setv(input int i, input logic v, input logic [DW_IN-1:0] d, input logic l,
                        input logic ev, input logic [DW_OUT-1:0] ed, input logic el,
                        input logic er, input logic [CW-1:0] ec);
        tbl[i] = '{sv: v, sd: d, sl: l, ev: ev, ed: ed, el: el, er: er, ec: ec};
    endtask

    task automatic rand_word();
        for (int k = 0; k < 8; k++) s_axis_tdata[k*32 +: 32] = $urandom();
    endtask

    initial begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        stall_clear   = 1'b0;
        repeat (3) @(posedge aclk);
        #2 areset = 1'b0;

        // Single word, then four back-to-back words with a continuous source.
        w0 = {{8{16'hBBBB}}, {8{16'hAAAA}}};
        for (int k = 1; k <= 5; k++) wk[k] = mkw(16'(k));
        setv(0,  1, w0,    1, 0, '0,              0, 1, 0);
        setv(1,  0, '0,    0, 1, {8{16'hAAAA}},   0, 0, 0);
        setv(2,  0, '0,    0, 1, {8{16'hBBBB}},   1, 1, 0);
        setv(3,  0, '0,    0, 0, '0,              0, 1, 0);
        setv(4,  1, wk[1], 0, 0, '0,              0, 1, 0);
        setv(5,  1, wk[2], 0, 1, wk[1][127:0],    0, 0, 0);
        setv(6,  1, wk[2], 0, 1, wk[1][255:128],  0, 1, 1);
        setv(7,  1, wk[3], 0, 1, wk[2][127:0],    0, 0, 1);
        setv(8,  1, wk[3], 0, 1, wk[2][255:128],  0, 1, 2);
        setv(9,  1, wk[4], 1, 1, wk[3][127:0],    0, 0, 2);
        setv(10, 1, wk[4], 1, 1, wk[3][255:128],  0, 1, 3);
        setv(11, 1, wk[5], 0, 1, wk[4][127:0],    0, 0, 3);
        setv(12, 0, '0,    0, 1, wk[4][255:128],  1, 1, 4);
        setv(13, 0, '0,    0, 0, '0,              0, 1, 4);
        for (int i = 0; i < NV; i++) begin
            @(posedge aclk);
            #1;
            s_axis_tvalid = tbl[i].sv;
            s_axis_tdata  = tbl[i].sd;
            s_axis_tlast  = tbl[i].sl;
            m_axis_tready = 1'b1;
            @(negedge aclk);
            chk($sformatf("tbl%0d_m_tvalid", i), m_axis_tvalid, tbl[i].ev);
            chk($sformatf("tbl%0d_s_tready", i), s_axis_tready, tbl[i].er);
            chk($sformatf("tbl%0d_stall_count", i), stall_count, tbl[i].ec);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_m_tdata", i), m_axis_tdata, tbl[i].ed);
                chk($sformatf("tbl%0d_m_tlast", i), m_axis_tlast, tbl[i].el);
            end
        end

        // Random traffic with random back-pressure and occasional clears.
        s_axis_tvalid = 1'b0;
        hs    = 1'b0;
        words = 0;
        cyc   = 0;
        while (words < 1000 && cyc < 20000) begin
            @(posedge aclk);
            #1;
            if (!s_axis_tvalid || hs) begin
                if ($urandom_range(0, 9) < 7) begin
                    s_axis_tvalid = 1'b1;
                    rand_word();
                    s_axis_tlast = 1'($urandom_range(0, 1));
                end else begin
                    s_axis_tvalid = 1'b0;
                end
            end
            m_axis_tready = 1'($urandom_range(0, 1));
            stall_clear   = ($urandom_range(0, 49) == 0);
            @(negedge aclk);
            hs = s_axis_tvalid && s_axis_tready;
            if (hs) words++;
            cyc++;
        end
        chk("random_words_accepted", words, 1000);

        // Drain everything still queued.
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        stall_clear   = 1'b0;
        repeat (4) @(posedge aclk);
        @(negedge aclk);
        chk("drain_queue_empty", q.size(), 0);
        chk("drain_m_tvalid", m_axis_tvalid, 0);

        // Saturation on the narrow counter: source held, sink blocked.
        #2 areset = 1'b1;
        @(negedge aclk);
        #2 areset = 1'b0;
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b1;
        rand_word();
        wsat = s_axis_tdata;
        s_axis_tlast  = 1'b1;
        m_axis_tready = 1'b0;
        repeat (40) @(posedge aclk);
        #1;
        chk("sat_count_narrow", stall_count_s, 15);
        chk("sat_count_wide", stall_count, 39);
        stall_clear = 1'b1;
        @(posedge aclk);
        #1;
        chk("sat_clear_narrow", stall_count_s, 0);
        chk("sat_clear_wide", stall_count, 0);
        stall_clear = 1'b0;

        // Move into UPPER and hold there, then reset off-edge.
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b0;
        chk("upper_m_tdata", m_axis_tdata, wsat[255:128]);
        chk("upper_m_tlast", m_axis_tlast, 1);
        #2 areset = 1'b1;
        #1;
        chk("async_rst_m_tvalid", m_axis_tvalid, 0);
        chk("async_rst_s_tready", s_axis_tready, 0);
        chk("async_rst_m_tdata", m_axis_tdata, 0);
        @(negedge aclk);
        #2 areset = 1'b0;

        // Next word after release must start with its lower half.
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b1;
        rand_word();
        wnew          = s_axis_tdata;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge aclk);
        chk("post_rst_s_tready", s_axis_tready, 1);
        chk("post_rst_m_tvalid", m_axis_tvalid, 0);
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        @(negedge aclk);
        chk("post_rst_lower", m_axis_tdata, wnew[127:0]);
        chk("post_rst_lower_last", m_axis_tlast, 0);
        @(negedge aclk);
        chk("post_rst_upper", m_axis_tdata, wnew[255:128]);
        @(negedge aclk);
        chk("post_rst_idle", m_axis_tvalid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
